alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Sequencer and two-port arbiter for the shared 64-bit ALU. It accepts operation requests from two requesters over valid/ready handshakes and grants them round-robin. It holds the winning operands stable on the ALU for the opcode-dependent latency (single-cycle for simple ops, multi-cycle for multiply/divide), then returns the captured result, flag and branch outputs to the winner. It also keeps a per-requester F1/F2 flag history that feeds the ALU's conditional ops.

## Interface
Parameters:
- MUL_LAT, 4: cycles opcode 16 (multiply) is held on the ALU (>=1)
- DIV_LAT, 16: cycles opcode 17 (divide) is held on the ALU (>=1)

Ports (requester i occupies slice i of each packed bus):
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  2  request valid per requester
- req_ready  out  2  request accepted this cycle (combinational)
- req_instr  in  12  opcode, [6i+5:6i]
- req_a, req_b, req_reg8  in  128 each  operands, [64i+63:64i]
- req_value  in  64  load immediate, [32i+31:32i]
- req_highlow  in  2  load half select
- rsp_valid  out  2  response valid to requester i
- rsp_ready  in  2  requester i takes response
- rsp_c, rsp_naddr  out  64 each  captured result / branch target
- rsp_flag, rsp_addrch, rsp_err  out  1 each  captured F3, branch-taken, error
- alu_instr  out  6; alu_a, alu_b, alu_reg8  out  64; alu_value  out  32; alu_highlow, alu_f1, alu_f2  out  1: registered drive to ALU
- alu_c, alu_naddr  in  64; alu_f3, alu_addrch  in  1: ALU outputs
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: arbitrate. If one req_valid is high, grant it. If both are high, grant the one not served last. req_ready[g]=1 only for the grant, only in IDLE.
- On accept, latch the granted operands into the alu_* registers. Drive alu_f1/alu_f2 from the granted requester's flag history. Record the grant, then go to EXEC. The round-robin pointer updates only on accept.
- EXEC: a down-counter loads MUL_LAT-1 for opcode 16, DIV_LAT-1 for 17, else 0. Decrement each cycle. When it reaches 0, capture alu_c/alu_f3/alu_addrch/alu_naddr into the rsp_* registers and go to RESP.
- Divide by zero (opcode 17, B==0): EXEC lasts 1 cycle. rsp_c=all-ones, rsp_err=1, rsp_flag=rsp_addrch=0, rsp_naddr=0.
- Opcodes 18..63: EXEC lasts 1 cycle. Capture ALU outputs as-is (zero) and set rsp_err=1.
- Flag history: at capture, if opcode is 8..13, the granted requester's F2<=F1 and F1<=alu_f3. Other opcodes leave history unchanged. The two histories are independent.
- RESP: rsp_valid[g]=1 and the other bit is 0. rsp_* are held stable until rsp_ready[g]; then go to IDLE. rsp_ready of the non-granted requester is ignored.

## Timing
- Accept in cycle n (valid&ready high). The ALU sees the new operands in cycle n+1.
- Capture occurs at the end of cycle n+1+L, where L = counter load value. rsp_valid rises in cycle n+2+L.
- With rsp_ready already high: IDLE in n+3+L, next accept earliest at n+3+L. Simple-op throughput is one per 3 cycles. Multiply with MUL_LAT=4 responds at n+5.
- Simultaneous requests arriving in RESP wait; the winner is chosen in the IDLE cycle with the current pointer.
- Reset values (reset_n low, any time):
  - FSM=IDLE; busy=0; req_ready=0; rsp_valid=0.
  - rsp_* and alu_* all 0; both flag histories 0.
  - Round-robin pointer = "last served 1", so req0 wins the first tie.
- Reset mid-EXEC or mid-RESP drops the in-flight op. No response is ever produced for it.
- Operands on req_* may change freely after accept; only latched copies are used.

## Test plan
- Single add: req0 instr=0, A=5, B=7, accepted cycle 0 -> rsp_valid[0] in cycle 2, rsp_c=12, rsp_err=0, rsp_valid[1]=0.
- Tie arbitration: both valid continuously with instr=1 (A=10, B=3) -> grants alternate req0, req1, req0. Each rsp_c=7 on the matching rsp_valid bit. The loser's req_ready stays 0.
- Multi-cycle: req1 multiply 3*4, MUL_LAT=4 -> rsp_valid[1] rises exactly 5 cycles after accept, rsp_c=12. Divide 100/7, DIV_LAT=16 -> response 17 cycles after accept, rsp_c=14.
- Flags and divide-by-zero:
  - req0 instr=8, A=B=9 -> rsp_flag=1, req0 F1=1.
  - Then req0 instr=13 -> alu_f1=1 at the ALU, rsp_flag=1. req1's history stays 0.
  - Divide by zero, B=0 -> rsp_c=0xFFFFFFFFFFFFFFFF, rsp_err=1 after 1 EXEC cycle.
- Back-pressure: hold rsp_ready[0]=0 for 10 cycles with req1 valid -> rsp_* stable, req_ready=0 throughout. Release -> IDLE next cycle, req1 accepted.
- Reset mid-op: pull reset_n low during a DIV EXEC -> busy/rsp_valid/req_ready=0 immediately, alu_* = 0. After release, no stale response, and req0 wins the first tie.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// Requester-side bus of the shared ALU issue controller.
// Requester i occupies slice i of every packed field.
interface alu_issue_ctrl_if;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [11:0]  req_instr;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [127:0] req_reg8;
    logic [63:0]  req_value;
    logic [1:0]   req_highlow;

    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready;
    logic [63:0]  rsp_c;
    logic [63:0]  rsp_naddr;
    logic         rsp_flag;
    logic         rsp_addrch;
    logic         rsp_err;

    modport master (
        output req_valid, req_instr, req_a, req_b, req_reg8, req_value, req_highlow, rsp_ready,
        input  req_ready, rsp_valid, rsp_c, rsp_naddr, rsp_flag, rsp_addrch, rsp_err
    );

    modport slave (
        input  req_valid, req_instr, req_a, req_b, req_reg8, req_value, req_highlow, rsp_ready,
        output req_ready, rsp_valid, rsp_c, rsp_naddr, rsp_flag, rsp_addrch, rsp_err
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Two-port round-robin issue controller for the shared 64-bit ALU.
// Latches the winner's operands onto the ALU, holds them for the
// opcode-dependent latency, then returns the captured result to the winner.
// Keeps an independent F1/F2 flag history per requester.
module alu_issue_ctrl #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    alu_issue_ctrl_if.slave  bus,
    output logic [5:0]       alu_instr,
    output logic [63:0]      alu_a,
    output logic [63:0]      alu_b,
    output logic [63:0]      alu_reg8,
    output logic [31:0]      alu_value,
    output logic             alu_highlow,
    output logic             alu_f1,
    output logic             alu_f2,
    input  logic [63:0]      alu_c,
    input  logic [63:0]      alu_naddr,
    input  logic             alu_f3,
    input  logic             alu_addrch,
    output logic             busy
);
    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [5:0] OP_MUL       = 6'd16;
    localparam logic [5:0] OP_DIV       = 6'd17;
    localparam logic [5:0] OP_FLAG_LO   = 6'd8;
    localparam logic [5:0] OP_FLAG_HI   = 6'd13;
    localparam logic [5:0] OP_FIRST_BAD = 6'd18;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state;
    state_t        state_nxt;

    logic          sel;
    logic          grant;
    logic          last;
    logic          accept;
    logic          capture;
    logic          div0;
    logic          flags_op;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_load;
    logic [1:0]    f1_hist;
    logic [1:0]    f2_hist;
    logic [1:0]    rdy;
    logic [1:0]    rv;

    logic [5:0]    sel_instr;
    logic [63:0]   sel_a;
    logic [63:0]   sel_b;
    logic [63:0]   sel_reg8;
    logic [31:0]   sel_value;
    logic          sel_highlow;

    logic [63:0]   rsp_c;
    logic [63:0]   rsp_naddr;
    logic          rsp_flag;
    logic          rsp_addrch;
    logic          rsp_err;

    // Round-robin pick, operand mux and latency selection for the candidate
    always_comb begin
        if (bus.req_valid == 2'b11) sel = ~last;
        else                        sel = ~bus.req_valid[0];

        sel_instr   = sel ? bus.req_instr[11:6]    : bus.req_instr[5:0];
        sel_a       = sel ? bus.req_a[127:64]      : bus.req_a[63:0];
        sel_b       = sel ? bus.req_b[127:64]      : bus.req_b[63:0];
        sel_reg8    = sel ? bus.req_reg8[127:64]   : bus.req_reg8[63:0];
        sel_value   = sel ? bus.req_value[63:32]   : bus.req_value[31:0];
        sel_highlow = sel ? bus.req_highlow[1]     : bus.req_highlow[0];

        // Divide by zero is resolved by the controller, so it never waits
        if (sel_instr == OP_MUL)                      cnt_load = CW'(MUL_LAT - 1);
        else if (sel_instr == OP_DIV && sel_b != '0)  cnt_load = CW'(DIV_LAT - 1);
        else                                          cnt_load = '0;
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state and handshake strobes
    always_comb begin
        state_nxt = state;
        rdy       = '0;
        rv        = '0;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid != '0) begin
                    accept    = 1'b1;
                    rdy[sel]  = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rv[grant] = 1'b1;
                if (bus.rsp_ready[grant]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, latency counter and round-robin bookkeeping
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alu_instr   <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_reg8    <= '0;
            alu_value   <= '0;
            alu_highlow <= 1'b0;
            alu_f1      <= 1'b0;
            alu_f2      <= 1'b0;
            grant       <= 1'b0;
            last        <= 1'b1;
            cnt         <= '0;
            div0        <= 1'b0;
        end else if (accept) begin
            alu_instr   <= sel_instr;
            alu_a       <= sel_a;
            alu_b       <= sel_b;
            alu_reg8    <= sel_reg8;
            alu_value   <= sel_value;
            alu_highlow <= sel_highlow;
            alu_f1      <= f1_hist[sel];
            alu_f2      <= f2_hist[sel];
            grant       <= sel;
            last        <= sel;
            cnt         <= cnt_load;
            div0        <= (sel_instr == OP_DIV) && (sel_b == '0);
        end else if (state == EXEC && cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign flags_op = (alu_instr >= OP_FLAG_LO) && (alu_instr <= OP_FLAG_HI);

    // Response capture and per-requester flag history update
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_c      <= '0;
            rsp_naddr  <= '0;
            rsp_flag   <= 1'b0;
            rsp_addrch <= 1'b0;
            rsp_err    <= 1'b0;
            f1_hist    <= '0;
            f2_hist    <= '0;
        end else if (capture) begin
            if (div0) begin
                rsp_c      <= '1;
                rsp_naddr  <= '0;
                rsp_flag   <= 1'b0;
                rsp_addrch <= 1'b0;
                rsp_err    <= 1'b1;
            end else begin
                rsp_c      <= alu_c;
                rsp_naddr  <= alu_naddr;
                rsp_flag   <= alu_f3;
                rsp_addrch <= alu_addrch;
                rsp_err    <= (alu_instr >= OP_FIRST_BAD);
            end
            if (flags_op) begin
                f2_hist[grant] <= f1_hist[grant];
                f1_hist[grant] <= alu_f3;
            end
        end
    end

    // Ready is suppressed while reset is asserted even though the FSM sits in IDLE
    assign bus.req_ready  = rdy & {2{reset_n}};
    assign bus.rsp_valid  = rv;
    assign bus.rsp_c      = rsp_c;
    assign bus.rsp_naddr  = rsp_naddr;
    assign bus.rsp_flag   = rsp_flag;
    assign bus.rsp_addrch = rsp_addrch;
    assign bus.rsp_err    = rsp_err;
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios followed by
// randomized traffic, checked against a transaction-level timeline model.
module tb_alu_issue_ctrl;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 16;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [5:0]  alu_instr;
    logic [63:0] alu_a, alu_b, alu_reg8, alu_c, alu_naddr;
    logic [31:0] alu_value;
    logic        alu_highlow, alu_f1, alu_f2, alu_f3, alu_addrch, busy;

    always #5 clock = ~clock;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus),
        .alu_instr(alu_instr), .alu_a(alu_a), .alu_b(alu_b), .alu_reg8(alu_reg8),
        .alu_value(alu_value), .alu_highlow(alu_highlow), .alu_f1(alu_f1), .alu_f2(alu_f2),
        .alu_c(alu_c), .alu_naddr(alu_naddr), .alu_f3(alu_f3), .alu_addrch(alu_addrch),
        .busy(busy)
    );

    typedef struct packed {
        logic [63:0] c;
        logic        f3;
        logic        addrch;
        logic [63:0] naddr;
    } alu_out_t;

    // Behaviour of the attached ALU; opcodes 18 and up produce zeros
    function automatic alu_out_t alu_ref(input logic [5:0] op, input logic [63:0] a, b, r8,
                                         input logic [31:0] v, input logic hl, f1, f2);
        alu_out_t o;
        o = '0;
        if (op <= 6'd13) o.naddr = a ^ r8;
        case (op)
            6'd0:  o.c = a + b;
            6'd1:  o.c = a - b;
            6'd2:  o.c = a & b;
            6'd3:  o.c = a | b;
            6'd4:  o.c = a ^ b;
            6'd5:  o.c = a << b[5:0];
            6'd8:  begin o.c = a - b; o.f3 = (a == b);        end
            6'd9:  begin o.c = a - b; o.f3 = (a != b);        end
            6'd10: begin o.c = a - b; o.f3 = (a < b);         end
            6'd11: begin o.c = a - b; o.f3 = (a > b);         end
            6'd12: begin o.c = a - b; o.f3 = (a == b) ^ f2;   end
            6'd13: begin o.c = a - b; o.f3 = (a == b) | f1;   end
            6'd14: begin o.c = a; o.addrch = f1; o.naddr = f1 ? r8 : a + 64'd4; end
            6'd15: o.c = hl ? {v, b[31:0]} : {b[63:32], v};
            6'd16: begin o.c = a * b; o.naddr = r8; end
            6'd17: begin o.c = (b != 0) ? a / b : '0; o.naddr = r8; end
            default: o = '0;
        endcase
        return o;
    endfunction

    alu_out_t alu_now;
    always_comb begin
        alu_now    = alu_ref(alu_instr, alu_a, alu_b, alu_reg8, alu_value, alu_highlow, alu_f1, alu_f2);
        alu_c      = alu_now.c;
        alu_f3     = alu_now.f3;
        alu_addrch = alu_now.addrch;
        alu_naddr  = alu_now.naddr;
    end

    // Requester drive state
    logic [1:0]  d_v = '0;
    logic [1:0]  d_rr = '0;
    logic [5:0]  d_op [2];
    logic [63:0] d_a [2], d_b [2], d_r8 [2];
    logic [31:0] d_val [2];
    logic        d_hl [2];
    bit          hold_req [2];
    bit          rand_mode = 0;

    // Reference model
    bit          m_inflight, m_last, m_owner;
    int          m_acc_cyc, m_resp_at, cyc;
    logic [1:0]  m_f1, m_f2;
    logic [5:0]  m_op;
    logic [63:0] m_a, m_b, m_r8, m_c, m_naddr;
    logic [31:0] m_val;
    logic        m_hl, m_af1, m_af2;
    logic [2:0]  m_fae;

    // Observations taken at the sampling edge
    logic [1:0]  obs_rdy, obs_rv;
    logic [63:0] obs_c;
    logic        obs_flag, obs_err, obs_af1, exec_f1;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int hold_of(input logic [5:0] op, input logic [63:0] b);
        if (op == 6'd16) return MUL_LAT;
        if (op == 6'd17 && b != 0) return DIV_LAT;
        return 1;
    endfunction

    task automatic model_reset();
        m_inflight = 0; m_last = 1; m_f1 = '0; m_f2 = '0;
    endtask

    task automatic set_req(input int i, input logic [5:0] op, input logic [63:0] a, b);
        d_v[i] = 1'b1; d_op[i] = op; d_a[i] = a; d_b[i] = b;
        d_r8[i] = 64'h1000 + 64'(i); d_val[i] = 32'hA5A5_0000 | 32'(i); d_hl[i] = 1'b0;
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < 2; i++) begin
            if (d_v[i]) begin
                bus.req_instr[6*i +: 6]  = d_op[i];
                bus.req_a[64*i +: 64]    = d_a[i];
                bus.req_b[64*i +: 64]    = d_b[i];
                bus.req_reg8[64*i +: 64] = d_r8[i];
                bus.req_value[32*i +: 32] = d_val[i];
                bus.req_highlow[i]       = d_hl[i];
            end else begin
                bus.req_instr[6*i +: 6]  = 6'($urandom);
                bus.req_a[64*i +: 64]    = {$urandom, $urandom};
                bus.req_b[64*i +: 64]    = {$urandom, $urandom};
                bus.req_reg8[64*i +: 64] = {$urandom, $urandom};
                bus.req_value[32*i +: 32] = $urandom;
                bus.req_highlow[i]       = 1'($urandom);
            end
        end
        bus.req_valid = d_v;
        bus.rsp_ready = d_rr;
    endtask

    task automatic gen_random();
        int r;
        logic [5:0] op;
        logic [63:0] a, b;
        for (int i = 0; i < 2; i++) begin
            if (!d_v[i] && $urandom_range(0, 2) == 0) begin
                r = $urandom_range(0, 19);
                a = {$urandom, $urandom};
                b = {$urandom, $urandom};
                if (r <= 5)       op = 6'(r);
                else if (r <= 11) op = 6'(r + 2);
                else if (r == 12) op = 6'd14;
                else if (r == 13) op = 6'd15;
                else if (r == 14) op = 6'd16;
                else if (r <= 16) begin op = 6'd17; b = 64'($urandom_range(0, 12)); end
                else if (r == 17) op = 6'($urandom_range(18, 63));
                else              op = 6'($urandom_range(0, 1));
                if (op >= 6'd8 && op <= 6'd13 && $urandom_range(0, 1) == 1) b = a;
                set_req(i, op, a, b);
                d_r8[i] = {$urandom, $urandom};
                d_val[i] = $urandom;
                d_hl[i] = 1'($urandom);
            end
        end
        d_rr[0] = ($urandom_range(0, 9) < 7);
        d_rr[1] = ($urandom_range(0, 9) < 7);
    endtask

    // Compare the DUT against the timeline model, then advance the model
    task automatic model_step();
        logic [1:0] exp_rdy, exp_rv;
        bit g, acc;
        alu_out_t o;
        exp_rdy = '0; exp_rv = '0; acc = 0; g = 0;
        obs_rdy = bus.req_ready; obs_rv = bus.rsp_valid; obs_c = bus.rsp_c;
        obs_flag = bus.rsp_flag; obs_err = bus.rsp_err; obs_af1 = alu_f1;

        if (!m_inflight && d_v != 2'b00) begin
            g = (d_v == 2'b11) ? ~m_last : ~d_v[0];
            exp_rdy[g] = 1'b1;
            acc = 1;
        end
        if (m_inflight && cyc >= m_resp_at) exp_rv[m_owner] = 1'b1;

        check("req_ready", bus.req_ready, exp_rdy);
        check("rsp_valid", bus.rsp_valid, exp_rv);
        check("busy", busy, m_inflight);
        if (m_inflight && cyc < m_resp_at) begin
            check("alu_a", alu_a, m_a);
            check("alu_b", alu_b, m_b);
            check("alu_reg8", alu_reg8, m_r8);
            check("alu_ctl", {alu_value, alu_instr, alu_highlow, alu_f1, alu_f2},
                  {m_val, m_op, m_hl, m_af1, m_af2});
        end
        if (exp_rv != 2'b00) begin
            check("rsp_c", bus.rsp_c, m_c);
            check("rsp_naddr", bus.rsp_naddr, m_naddr);
            check("rsp_fae", {bus.rsp_flag, bus.rsp_addrch, bus.rsp_err}, m_fae);
            if (d_rr[m_owner]) m_inflight = 0;
        end

        if (acc) begin
            m_op = d_op[g]; m_a = d_a[g]; m_b = d_b[g]; m_r8 = d_r8[g];
            m_val = d_val[g]; m_hl = d_hl[g]; m_af1 = m_f1[g]; m_af2 = m_f2[g];
            o = alu_ref(m_op, m_a, m_b, m_r8, m_val, m_hl, m_af1, m_af2);
            if (m_op == 6'd17 && m_b == 0) begin
                m_c = '1; m_naddr = '0; m_fae = 3'b001;
            end else begin
                m_c = o.c; m_naddr = o.naddr; m_fae = {o.f3, o.addrch, m_op >= 6'd18};
            end
            if (m_op >= 6'd8 && m_op <= 6'd13) begin
                m_f2[g] = m_f1[g];
                m_f1[g] = o.f3;
            end
            m_inflight = 1; m_owner = g; m_last = g;
            m_acc_cyc = cyc; m_resp_at = cyc + 1 + hold_of(m_op, m_b);
            if (!hold_req[g]) d_v[g] = 1'b0;
        end
    endtask

    task automatic tick();
        if (rand_mode) gen_random();
        apply_inputs();
        @(negedge clock);
        model_step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic wait_accept(input int i, input string tag);
        int k;
        k = 0;
        do begin tick(); k++; end while (!obs_rdy[i] && k < 30);
        check({tag, "_acc"}, obs_rdy[i], 1'b1);
    endtask

    task automatic run_op(input int i, input logic [5:0] op, input logic [63:0] a, b,
                          input int exp_lat, input logic [63:0] exp_c, input logic [1:0] exp_fe,
                          input string tag);
        int n;
        set_req(i, op, a, b);
        d_rr = 2'b11;
        wait_accept(i, tag);
        n = 0;
        do begin
            tick(); n++;
            if (n == 1) exec_f1 = obs_af1;
        end while (!obs_rv[i] && n < 40);
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_c"}, obs_c, exp_c);
        check({tag, "_fe"}, {obs_flag, obs_err}, exp_fe);
    endtask

    task automatic drain();
        int k;
        d_v = '0; d_rr = 2'b11; rand_mode = 0;
        k = 0;
        while (m_inflight && k < 60) begin tick(); k++; end
        check("drain_idle", busy, 1'b0);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_rdy"}, bus.req_ready, 2'b00);
        check({tag, "_rv"}, bus.rsp_valid, 2'b00);
        check({tag, "_c"}, bus.rsp_c, 64'd0);
        check({tag, "_naddr"}, bus.rsp_naddr, 64'd0);
        check({tag, "_alu_a"}, alu_a, 64'd0);
        check({tag, "_alu_ctl"}, {alu_instr, alu_f1, alu_f2, alu_b[31:0]}, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int k, gi;
        logic [2:0] seq;
        cyc = 0;
        hold_req[0] = 0; hold_req[1] = 0;
        model_reset();
        // Both requesters asserted while in reset: ready must stay low
        set_req(0, 6'd1, 64'd10, 64'd3);
        set_req(1, 6'd1, 64'd10, 64'd3);
        apply_inputs();
        #2;
        reset_checks("rst");
        @(posedge clock); #1;
        reset_checks("rst2");
        reset_n = 1'b1;

        // Tie arbitration: grants alternate starting with req0
        hold_req[0] = 1; hold_req[1] = 1; d_rr = 2'b11;
        gi = 0; k = 0; seq = '0;
        while (gi < 3 && k < 40) begin
            tick(); k++;
            if (obs_rdy != 2'b00) begin
                seq[gi] = obs_rdy[1];
                gi++;
            end
        end
        hold_req[0] = 0; hold_req[1] = 0;
        check("tie_count", gi, 3);
        check("tie_g0", seq[0], 1'b0);
        check("tie_g1", seq[1], 1'b1);
        check("tie_g2", seq[2], 1'b0);
        drain();

        run_op(0, 6'd0, 64'd5, 64'd7, 2, 64'd12, 2'b00, "add");
        run_op(1, 6'd16, 64'd3, 64'd4, MUL_LAT + 1, 64'd12, 2'b00, "mul");
        run_op(1, 6'd17, 64'd100, 64'd7, DIV_LAT + 1, 64'd14, 2'b00, "div");
        run_op(0, 6'd8, 64'd9, 64'd9, 2, 64'd0, 2'b10, "cmp8");
        run_op(0, 6'd13, 64'd1, 64'd2, 2, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, "cmp13");
        check("cmp13_f1", exec_f1, 1'b1);
        run_op(1, 6'd0, 64'd1, 64'd1, 2, 64'd2, 2'b00, "req1_hist");
        check("req1_f1", exec_f1, 1'b0);
        run_op(0, 6'd17, 64'd5, 64'd0, 2, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01, "div0");
        run_op(1, 6'd40, 64'd5, 64'd6, 2, 64'd0, 2'b01, "badop");
        drain();

        // Back-pressure on req0 while req1 waits
        set_req(0, 6'd0, 64'd20, 64'd22);
        d_rr = 2'b10;
        wait_accept(0, "bp");
        set_req(1, 6'd1, 64'd50, 64'd8);
        k = 0;
        do begin tick(); k++; end while (!obs_rv[0] && k < 10);
        for (int j = 0; j < 10; j++) begin
            tick();
            check("bp_ready", obs_rdy, 2'b00);
            check("bp_valid", obs_rv, 2'b01);
            check("bp_c", obs_c, 64'd42);
        end
        d_rr = 2'b11;
        tick();
        tick();
        check("bp_next", obs_rdy, 2'b10);
        drain();

        // Randomized traffic
        rand_mode = 1;
        repeat (2000) tick();
        drain();

        // Reset in the middle of a divide
        set_req(0, 6'd17, 64'd100, 64'd7);
        d_rr = 2'b11;
        wait_accept(0, "mid");
        repeat (5) tick();
        set_req(0, 6'd1, 64'd10, 64'd3);
        set_req(1, 6'd1, 64'd10, 64'd3);
        reset_n = 1'b0;
        apply_inputs();
        #1;
        reset_checks("mid_rst");
        repeat (2) @(posedge clock);
        #1;
        reset_checks("mid_rst2");
        reset_n = 1'b1;
        model_reset();
        tick();
        check("mid_first_tie", obs_rdy, 2'b01);
        drain();
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
